// File: rtl/aud_btm_rx.sv
// aud_btm_rx: AUD branch-trace receiver; rebuilds branch addresses from nibble bursts
// and queues {addr, mode, partial} records in a first-word-fall-through FIFO.
module aud_btm_rx #(
    parameter int ADDR_W     = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          aud_ck,
    input  logic                          rst,
    input  logic [3:0]                    aud_data,
    input  logic                          aud_nsync,
    input  logic                          br_ready,
    input  logic                          clr_ovf,
    output logic [ADDR_W-1:0]             br_addr,
    output logic [1:0]                    br_mode,
    output logic                          br_partial,
    output logic                          br_valid,
    output logic                          buserror,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int NW = ADDR_W / 4;
    localparam int CW = $clog2(NW + 2);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int RW = ADDR_W + 3;
    localparam logic [CW-1:0] E2 = CW'(NW < 4 ? NW : 4);
    localparam logic [CW-1:0] E3 = CW'(NW < 8 ? NW : 8);

    logic              recv;
    logic [CW-1:0]     count, e;
    logic [1:0]        mode;
    logic [ADDR_W-1:0] asm_addr, last_good, asm_next;
    logic [RW-1:0]     mem [FIFO_DEPTH];
    logic [RW-1:0]     rec, head_next;
    logic [PW-1:0]     rd_ptr, wr_ptr;
    logic [PW:0]       lvl_after_pop;
    logic              push, pop, full, wr_en;

    assign e = mode == 2'd0 ? CW'(1) : mode == 2'd1 ? CW'(2) : mode == 2'd2 ? E2 : E3;

    // A burst starts from the last good address so untransmitted upper nibbles carry over.
    always_comb begin
        asm_next = recv ? asm_addr : last_good;
        for (int i = 0; i < NW; i++)
            if (count == CW'(i)) asm_next[4*i +: 4] = aud_data;
    end

    always_ff @(posedge aud_ck) begin
        if (rst) begin
            recv      <= 1'b0;
            count     <= '0;
            mode      <= 2'd0;
            asm_addr  <= '0;
            last_good <= '0;
            buserror  <= 1'b0;
        end else begin
            recv <= !aud_nsync;
            if (!aud_nsync) begin
                buserror <= 1'b0;
                asm_addr <= asm_next;
                count    <= count == CW'(NW + 1) ? count : count + CW'(1);
            end else begin
                buserror <= !(aud_data == 4'b0011 || aud_data[3:2] == 2'b10);
                if (aud_data[3:2] == 2'b10) mode <= aud_data[1:0];
                if (count != '0) count <= '0;
                if (count != '0 && count == e) last_good <= asm_addr;
            end
        end
    end

    assign push          = aud_nsync && count != '0;
    assign rec           = {asm_addr, mode, count != e};
    assign br_valid      = fifo_level != '0;
    assign full          = fifo_level == (PW+1)'(FIFO_DEPTH);
    assign pop           = br_valid && br_ready;
    assign wr_en         = push && (!full || pop);
    assign lvl_after_pop = fifo_level - (PW+1)'(pop);
    // The head register takes the incoming record directly when the queue would otherwise be empty.
    assign head_next     = lvl_after_pop == '0 ? rec : mem[rd_ptr + PW'(pop)];

    always_ff @(posedge aud_ck) begin
        if (wr_en) mem[wr_ptr] <= rec;
    end

    always_ff @(posedge aud_ck) begin
        if (rst) begin
            rd_ptr                         <= '0;
            wr_ptr                         <= '0;
            fifo_level                     <= '0;
            {br_addr, br_mode, br_partial} <= '0;
            overflow                       <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            fifo_level                     <= fifo_level + (PW+1)'(wr_en) - (PW+1)'(pop);
            {br_addr, br_mode, br_partial} <= head_next;
            overflow                       <= (push && full && !pop) || (overflow && !clr_ovf);
        end
    end
endmodule

// File: doc/aud_btm_rx.md
AUD_BTM_RX -- requirements
Module: aud_btm_rx

Interface
REQ-001 Parameter: ADDR_W, default 32, reconstructed branch address width; multiple of 4, range 8..64.
REQ-002 Parameter: FIFO_DEPTH, default 8, record buffer depth; power of 2, at least 2.
REQ-003 aud_ck  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous active-high reset, sampled on the aud_ck rising edge.
REQ-005 aud_data  in  4  AUD nibble bus.
REQ-006 aud_nsync  in  1  low = address nibble cycle; high = header/sync cycle.
REQ-007 br_ready  in  1  consumer accepts the head record when high with br_valid.
REQ-008 clr_ovf  in  1  clears the overflow flag.
REQ-009 br_addr  out  ADDR_W  head record address.
REQ-010 br_mode  out  2  head record mode field.
REQ-011 br_partial  out  1  head record is an interrupted (incomplete) transfer.
REQ-012 br_valid  out  1  FIFO non-empty; head record present.
REQ-013 buserror  out  1  invalid header symbol sampled in the previous cycle.
REQ-014 overflow  out  1  sticky; a record was dropped because the FIFO was full.
REQ-015 fifo_level  out  $clog2(FIFO_DEPTH)+1  records currently held.

Function
REQ-016 Receiver states: IDLE (aud_nsync high) and RECV (aud_nsync low); the state follows aud_nsync each edge.
REQ-017 Header cycle, aud_data=4'b0011: sync symbol; buserror<=0; mode unchanged.
REQ-018 Header cycle, aud_data[3:2]=2'b10: mode<=aud_data[1:0]; buserror<=0.
REQ-019 Any other header value: buserror<=1 for exactly that cycle; mode unchanged.
REQ-020 Expected nibbles E = min(1<<mode, ADDR_W/4).
REQ-021 RECV cycle: nibble k (k = nibble count, starting at 0) writes asm[4k+3:4k]; count increments and saturates at ADDR_W/4+1; nibbles with k >= ADDR_W/4 are discarded.
REQ-022 On entering RECV, asm is preloaded from last_good; untransmitted upper bits therefore carry over from the last good address.
REQ-023 Completion: the first IDLE cycle with count != 0 pushes one record, then clears count.
REQ-024 Completion with count==E: record {asm, mode, partial=0}; last_good<=asm.
REQ-025 Completion with count!=E (short or overrun): record {asm, mode, partial=1}; last_good unchanged.
REQ-026 An IDLE cycle with count==0 pushes nothing.
REQ-027 A header symbol sampled in the completion cycle applies to the next record only.
REQ-028 FIFO is first-word-fall-through with registered outputs.
REQ-029 A record pushed at edge N is visible with br_valid=1 from edge N when the FIFO was empty (latency: 1 cycle after the last IDLE sample).
REQ-030 Pop occurs when br_valid and br_ready are both 1 at an edge.
REQ-031 br_addr, br_mode and br_partial hold stable while br_valid=1 and br_ready=0.
REQ-032 Push while full with no pop: record dropped; overflow<=1; contents and level unchanged.
REQ-033 Push while full with a simultaneous pop: both proceed; level unchanged; no overflow.
REQ-034 Pop while empty: ignored.
REQ-035 overflow clears on clr_ovf=1; a simultaneous new overflow event wins (flag stays 1).
REQ-036 Pointers wrap modulo FIFO_DEPTH; fifo_level ranges 0..FIFO_DEPTH.

Reset
REQ-037 While rst=1 at an edge: FIFO empty, fifo_level=0, br_valid=0, br_addr=0, br_mode=0, br_partial=0, buserror=0, overflow=0, mode=0, count=0, last_good=0.
REQ-038 Reset during RECV discards the in-progress record; no record is pushed after reset deasserts.
REQ-039 Reset has priority over all other inputs, including clr_ovf and br_ready.

Verification
REQ-040 Header 4'b1011, 8 nibbles 1..8 LSB first, then sync -> one record: br_addr=0x87654321, mode=3, partial=0, br_valid one cycle after the sync sample.
REQ-041 After REQ-040, header 4'b1001 then nibbles A,B -> br_addr=0x876543BA, partial=0.
REQ-042 Header mode 3, 3 nibbles F,F,F, then IDLE -> br_addr=last_good with bits [11:0]=0xFFF, partial=1; a following mode-0 nibble 0x5 merges onto the unchanged last_good.
REQ-043 br_ready=0, push FIFO_DEPTH+1 records -> fifo_level=FIFO_DEPTH, overflow=1, the last record lost; clr_ovf -> overflow=0.
REQ-044 Header value 4'b0110 -> buserror=1 for exactly one cycle and mode unchanged; 4'b0011 on the next cycle -> buserror=0.
REQ-045 rst pulsed mid-RECV with 2 records queued -> br_valid=0, fifo_level=0; the next full mode-0 record reconstructs from last_good=0.
